mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 90 +++++++++
 rtl/mem_ld_ext.sv | 29 ++
 rtl/mem_lsu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared constants, types and lane helpers for the load/store unit.
package mem_lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Load extender selection codes
  typedef enum logic [2:0] {
    EXT_NONE   = 3'd0,
    EXT_WORD   = 3'd1,
    EXT_HALF_S = 3'd2,
    EXT_HALF_U = 3'd3,
    EXT_BYTE_S = 3'd4,
    EXT_BYTE_U = 3'd5
  } ext_sel_e;

  // Bus command payload held stable for the whole BUS phase
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic            we;
    logic [XLEN-1:0] wdata;
  } bus_cmd_t;

  // Registered completion payload
  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            adel;
    logic            ades;
    logic            err;
  } resp_t;

  function automatic ext_sel_e ext_sel(input op_e op);
    case (op)
      OP_LW:   return EXT_WORD;
      OP_LH:   return EXT_HALF_S;
      OP_LHU:  return EXT_HALF_U;
      OP_LB:   return EXT_BYTE_S;
      OP_LBU:  return EXT_BYTE_U;
      default: return EXT_NONE;
    endcase
  endfunction

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lane_be(input op_e op, input logic [1:0] off);
    case (op)
      OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
      OP_SB:   return BE_W'(4'b0001 << off);
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input op_e op, input logic [XLEN-1:0] wd);
    case (op)
      OP_SH:   return {2{wd[15:0]}};
      OP_SB:   return {4{wd[7:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// Load data lane extraction and sign/zero extension (combinational).
module mem_ld_ext
  import mem_lsu_pkg::*;
(
  input  op_e             op_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] result_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Pick the addressed byte/half from the little-endian word and extend it
  always_comb begin
    byte_c     = 8'(word_i >> {off_i, 3'b000});
    half_c     = 16'(word_i >> {off_i[1], 4'b0000});
    result_c_o = '0;
    case (ext_sel(op_i))
      EXT_WORD:   result_c_o = word_i;
      EXT_HALF_S: result_c_o = {{16{half_c[15]}}, half_c};
      EXT_HALF_U: result_c_o = {16'h0000, half_c};
      EXT_BYTE_S: result_c_o = {{24{byte_c[7]}}, byte_c};
      EXT_BYTE_U: result_c_o = {24'h000000, byte_c};
      default:    result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit with alignment check and bus timeout.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            exc_adel,
  output logic            exc_ades,
  output logic            bus_err,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [BE_W-1:0] bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic               bus_req_q, bus_req_d;
  bus_cmd_t           cmd_q, cmd_d;
  logic               resp_valid_q, resp_valid_d;
  resp_t              resp_q, resp_d;
  op_e                req_op_c;
  logic [XLEN-1:0]    ld_data_c;

  assign req_op_c = op_e'(req_op);

  mem_ld_ext u_ld_ext (
    .op_i       (op_q),
    .off_i      (off_q),
    .word_i     (bus_rdata),
    .result_c_o (ld_data_c)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_LW;
      off_q        <= '0;
      bus_req_q    <= 1'b0;
      cmd_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      off_q        <= off_d;
      bus_req_q    <= bus_req_d;
      cmd_q        <= cmd_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  // Next-state and registered-output logic; response fields are zero outside RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    bus_req_d    = bus_req_q;
    cmd_d        = cmd_q;
    resp_valid_d = 1'b0;
    resp_d       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned(req_op_c, req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_d.adel  = !is_store(req_op_c);
            resp_d.ades  = is_store(req_op_c);
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            op_d        = req_op_c;
            off_d       = req_addr[1:0];
            bus_req_d   = 1'b1;
            cmd_d.addr  = {req_addr[XLEN-1:2], 2'b00};
            cmd_d.be    = lane_be(req_op_c, req_addr[1:0]);
            cmd_d.we    = is_store(req_op_c);
            cmd_d.wdata = lane_wdata(req_op_c, req_wdata);
          end
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_d      = ST_RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d.rdata = ld_data_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_d.err   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = (state_q == ST_BUS);
  assign bus_req    = bus_req_q;
  assign bus_we     = cmd_q.we;
  assign bus_addr   = cmd_q.addr;
  assign bus_be     = cmd_q.be;
  assign bus_wdata  = cmd_q.wdata;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_q.rdata;
  assign exc_adel   = resp_q.adel;
  assign exc_ades   = resp_q.ades;
  assign bus_err    = resp_q.err;

endmodule
